// File: rtl/div_pkg.sv
// div_pkg: shared state encoding, sizing constants and two's-complement helpers for div_unit.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;
  localparam int DIV_LATENCY = 34;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} div_state_t;
  function automatic logic [DIV_WIDTH-1:0] neg_w(input logic [DIV_WIDTH-1:0] x);
    return '0 - x;
  endfunction
  function automatic logic [DIV_WIDTH-1:0] abs_w(input logic [DIV_WIDTH-1:0] x);
    return x[DIV_WIDTH-1] ? neg_w(x) : x;
  endfunction
endpackage

// File: rtl/div_unit.sv
// div_unit: sequential signed restoring divider (MIPS div), one quotient bit per clock.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             DivControl,
  input  logic [WIDTH-1:0] DivA,
  input  logic [WIDTH-1:0] DivB,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivZero,
  output logic             Busy,
  output logic             out
);
  localparam int CW = $clog2(WIDTH) + 1;
  div_state_t state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
  logic sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_x, trial;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    sa_d = sa_q;
    sb_d = sb_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    dz_d = dz_q;
    // the bit shifted out of rem takes part in the trial, so rem never overflows for divisors >= 2^(W-1)
    rem_x = {rem_q, quo_q[WIDTH-1]};
    trial = rem_x - {1'b0, dvs_q};
    case (state_q)
      IDLE: if (DivControl) begin
        if (DivB == '0) begin
          dz_d = 1'b1;
          state_d = DONE;
        end else begin
          dz_d = 1'b0;
          dvs_d = abs_w(DivB);
          quo_d = abs_w(DivA);
          sa_d = DivA[WIDTH-1];
          sb_d = DivB[WIDTH-1];
          rem_d = '0;
          cnt_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = trial[WIDTH] ? rem_x[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : RUN;
      end
      FIX: begin
        lo_d = (sa_q ^ sb_q) ? neg_w(quo_q) : quo_q;
        hi_d = sa_q ? neg_w(rem_q) : rem_q;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      dz_q <= dz_d;
    end
  end
  assign Hi = hi_q;
  assign Lo = lo_q;
  assign DivZero = dz_q;
  assign Busy = state_q != IDLE;
  assign out = state_q == DONE;
endmodule
